// File: rtl/jtag_master.sv
// Host-side JTAG initiator: runs TAP reset, IR/DR scans and Run-Test/Idle clocking
// on TCK/TMS/TDI and returns the TDO bits captured during the shift phase.
//
// state   | meaning
// S_IDLE  | TAP parked in Run-Test/Idle, TCK low, waiting for a command
// S_RESET | six TCK periods, TMS 1,1,1,1,1,0 -> Run-Test/Idle
// S_HDR   | TMS walk from Run-Test/Idle to Shift-IR (1,1,0,0) or Shift-DR (1,0,0)
// S_SHIFT | one TCK period per bit, TMS high on the last bit
// S_TAIL  | TMS 1,0: Exit1 -> Update -> Run-Test/Idle
// S_RUN   | len TCK periods with TMS low
// S_DONE  | one cycle: response pulse, cmd_ready back up
module jtag_master #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6,
  parameter int DIV    = 2
) (
  input  logic              system_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  localparam int DW = $clog2(DIV + 1);
  localparam logic [DW-1:0]    DIV_LOAD = DW'(DIV - 1);
  localparam logic [DW-1:0]    DIV_ONE  = DW'(1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_HDR, S_SHIFT, S_TAIL, S_RUN, S_DONE
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    per_cnt;
  logic [DW-1:0]       div_cnt;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mask;
  logic                auto_rst;
  logic [LEN_W-1:0]    len_c;

  always_comb begin
    len_c = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state     <= S_RESET;
      op_q      <= OP_RESET;
      len_q     <= '0;
      per_cnt   <= LEN_W'(5);
      div_cnt   <= DIV_LOAD;
      data_q    <= '0;
      mask      <= '0;
      auto_rst  <= 1'b1;
      TCK       <= 1'b0;
      TMS       <= 1'b1;
      TDI       <= 1'b1;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          TCK <= 1'b0;
          TMS <= 1'b0;
          // The acceptance edge doubles as the launch edge of the first period.
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            len_q     <= len_c;
            data_q    <= cmd_data;
            mask      <= DATA_W'(1);
            rsp_data  <= '0;
            auto_rst  <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            div_cnt   <= DIV_LOAD;
            case (cmd_op)
              OP_RESET: begin
                state   <= S_RESET;
                per_cnt <= LEN_W'(5);
                TMS     <= 1'b1;
              end
              OP_IR, OP_DR: begin
                if (len_c == '0) begin
                  state <= S_DONE;
                end else begin
                  state   <= S_HDR;
                  per_cnt <= (cmd_op == OP_IR) ? LEN_W'(3) : LEN_W'(2);
                  TMS     <= 1'b1;
                end
              end
              default: begin
                state   <= (len_c == '0) ? S_DONE : S_RUN;
                per_cnt <= len_c - ONE;
              end
            endcase
          end
        end
        S_DONE: begin
          rsp_valid <= !auto_rst;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          TMS       <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_ONE;
          end else begin
            div_cnt <= DIV_LOAD;
            if (!TCK) begin
              TCK <= 1'b1;
              if (state == S_SHIFT) begin
                if (TDO) rsp_data <= rsp_data | mask;
                mask <= mask << 1;
              end
            end else begin
              // End of a period: launch the next TMS/TDI or leave the state.
              TCK <= 1'b0;
              if (per_cnt != '0) per_cnt <= per_cnt - ONE;
              case (state)
                S_RESET: begin
                  if (per_cnt == '0) state <= S_DONE;
                  else               TMS   <= (per_cnt != ONE);
                end
                S_HDR: begin
                  if (per_cnt == '0) begin
                    state   <= S_SHIFT;
                    per_cnt <= len_q - ONE;
                    TMS     <= (len_q == ONE);
                    TDI     <= data_q[0];
                    data_q  <= data_q >> 1;
                  end else begin
                    TMS <= (op_q == OP_IR) && (per_cnt == LEN_W'(3));
                  end
                end
                S_SHIFT: begin
                  if (per_cnt == '0) begin
                    state   <= S_TAIL;
                    per_cnt <= ONE;
                    TMS     <= 1'b1;
                  end else begin
                    TMS    <= (per_cnt == ONE);
                    TDI    <= data_q[0];
                    data_q <= data_q >> 1;
                  end
                end
                S_TAIL: begin
                  if (per_cnt == '0) state <= S_DONE;
                  else               TMS   <= 1'b0;
                end
                S_RUN: begin
                  if (per_cnt == '0) state <= S_DONE;
                end
                default: state <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
